// File: rtl/mem_bus_arbiter_if.sv
// Slave-side memory bus driven by mem_bus_arbiter.
// Request fields stay stable from req until ack.
interface mem_bus_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                req;
  logic                we;
  logic [ADDR_W-1:0]   addr;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                ack;
  logic                rvalid;
  logic [DATA_W-1:0]   rdata;

  modport master (
    output req, we, addr, wdata, wstrb,
    input  ack, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata, wstrb,
    output ack, rvalid, rdata
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one memory port between LSU (m0)
// and fetch (m1); one transfer in flight, timeout abort.
module mem_bus_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                m0_req_i,
  input  logic                m0_we_i,
  input  logic [ADDR_W-1:0]   m0_addr_i,
  input  logic [DATA_W-1:0]   m0_wdata_i,
  input  logic [DATA_W/8-1:0] m0_wstrb_i,
  output logic                m0_gnt_o,
  output logic                m0_done_o,
  output logic                m0_err_o,
  output logic [DATA_W-1:0]   m0_rdata_o,
  input  logic                m1_req_i,
  input  logic                m1_we_i,
  input  logic [ADDR_W-1:0]   m1_addr_i,
  input  logic [DATA_W-1:0]   m1_wdata_i,
  input  logic [DATA_W/8-1:0] m1_wstrb_i,
  output logic                m1_gnt_o,
  output logic                m1_done_o,
  output logic                m1_err_o,
  output logic [DATA_W-1:0]   m1_rdata_o,
  mem_bus_arbiter_if.master   s,
  output logic                busy_o
);
  localparam int SW    = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   last_q, last_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic [SW-1:0]          wstrb_q, wstrb_d;
  logic [1:0]             done_q, done_d;
  logic [1:0]             err_q, err_d;
  logic [1:0][DATA_W-1:0] rdata_q, rdata_d;

  logic [1:0] req;
  logic [1:0] gnt;
  logic       win;
  logic       fin;
  logic       abort;
  logic       tmo;

  assign req = {m1_req_i, m0_req_i};

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = '0;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    done_d  = '0;
    err_d   = err_q;
    rdata_d = rdata_q;
    gnt     = '0;
    win     = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    tmo     = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
    unique case (state_q)
      IDLE: begin
        if (!rst && |req) begin
          // On a tie the previous owner yields.
          win      = (&req) ? ~last_q : req[1];
          gnt[win] = 1'b1;
          owner_d  = win;
          last_d   = win;
          we_d     = win ? m1_we_i    : m0_we_i;
          addr_d   = win ? m1_addr_i  : m0_addr_i;
          wdata_d  = win ? m1_wdata_i : m0_wdata_i;
          wstrb_d  = win ? m1_wstrb_i : m0_wstrb_i;
          state_d  = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (s.ack && s.rvalid) fin = 1'b1;
        else if (tmo)          abort = 1'b1;
        else if (s.ack)        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (s.rvalid) fin = 1'b1;
        else if (tmo) abort = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (fin || abort) begin
      state_d          = IDLE;
      cnt_d            = '0;
      done_d[owner_q]  = 1'b1;
      err_d[owner_q]   = abort;
      rdata_d[owner_q] = (fin && !we_q) ? s.rdata : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign s.req   = (state_q == REQ);
  assign s.we    = we_q;
  assign s.addr  = addr_q;
  assign s.wdata = wdata_q;
  assign s.wstrb = wstrb_q;
  assign busy_o  = (state_q != IDLE);

  assign m0_gnt_o   = gnt[0];
  assign m1_gnt_o   = gnt[1];
  assign m0_done_o  = done_q[0];
  assign m1_done_o  = done_q[1];
  assign m0_err_o   = err_q[0];
  assign m1_err_o   = err_q[1];
  assign m0_rdata_o = rdata_q[0];
  assign m1_rdata_o = rdata_q[1];
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus a random
// transaction-level run against a scoreboard model.
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          m0_req, m0_we, m0_gnt, m0_done, m0_err;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic [SW-1:0] m0_wstrb;
  logic          m1_req, m1_we, m1_gnt, m1_done, m1_err;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic [SW-1:0] m1_wstrb;
  logic          busy;

  int n_pass;
  int n_total;

  mem_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) sbus ();

  mem_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
    .m0_wdata_i(m0_wdata), .m0_wstrb_i(m0_wstrb),
    .m0_gnt_o(m0_gnt), .m0_done_o(m0_done), .m0_err_o(m0_err),
    .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
    .m1_wdata_i(m1_wdata), .m1_wstrb_i(m1_wstrb),
    .m1_gnt_o(m1_gnt), .m1_done_o(m1_done), .m1_err_o(m1_err),
    .m1_rdata_o(m1_rdata),
    .s(sbus),
    .busy_o(busy)
  );

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
    sbus.ack = 0; sbus.rvalid = 0; sbus.rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    m0_req = 1; m1_req = 1; sbus.ack = 1; sbus.rvalid = 1;
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if ({m1_gnt, m0_gnt} !== 2'b00)
      $display("FAIL rst_gnt: got %b want 00", {m1_gnt, m0_gnt});
    else n_pass++;
    n_total++;
    if ({m1_done, m0_done, m1_err, m0_err} !== 4'b0)
      $display("FAIL rst_done_err: got %b want 0",
               {m1_done, m0_done, m1_err, m0_err});
    else n_pass++;
    n_total++;
    if ({m1_rdata, m0_rdata} !== '0)
      $display("FAIL rst_rdata: got %h %h want 0", m1_rdata, m0_rdata);
    else n_pass++;
    n_total++;
    if ({sbus.req, sbus.we, sbus.addr, sbus.wdata, sbus.wstrb, busy} !== '0)
      $display("FAIL rst_slave: req=%b we=%b addr=%h busy=%b want 0",
               sbus.req, sbus.we, sbus.addr, busy);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_read_min();
    do_reset();
    m1_req = 1; m1_we = 0; m1_addr = 32'h100;
    #1;
    n_total++;
    if ({m1_gnt, m0_gnt} !== 2'b10)
      $display("FAIL rd_gnt: got %b want 10", {m1_gnt, m0_gnt});
    else n_pass++;
    @(negedge clk);
    m1_req = 0; sbus.ack = 1; sbus.rvalid = 1; sbus.rdata = 32'hDEADBEEF;
    #1;
    n_total++;
    if ({sbus.req, sbus.we, sbus.addr} !== {1'b1, 1'b0, 32'h100})
      $display("FAIL rd_sreq: got req=%b we=%b addr=%h want 1 0 100",
               sbus.req, sbus.we, sbus.addr);
    else n_pass++;
    @(negedge clk);
    idle_inputs();
    #1;
    n_total++;
    if ({m1_done, m0_done, m1_err} !== 3'b100)
      $display("FAIL rd_done: got d1=%b d0=%b e1=%b want 1 0 0",
               m1_done, m0_done, m1_err);
    else n_pass++;
    n_total++;
    if (m1_rdata !== 32'hDEADBEEF)
      $display("FAIL rd_data: got %h want deadbeef", m1_rdata);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({m1_done, busy, m1_rdata} !== {2'b00, 32'hDEADBEEF})
      $display("FAIL rd_hold: got d=%b busy=%b rdata=%h", m1_done, busy,
               m1_rdata);
    else n_pass++;
  endtask

  task automatic test_tie();
    do_reset();
    m0_req = 1; m1_req = 1; m0_addr = 32'h10; m1_addr = 32'h20;
    #1;
    n_total++;
    if ({m1_gnt, m0_gnt} !== 2'b01)
      $display("FAIL tie_first: got %b want 01", {m1_gnt, m0_gnt});
    else n_pass++;
    @(negedge clk);
    m0_req = 0; sbus.ack = 1; sbus.rvalid = 1;
    #1;
    n_total++;
    if ({m1_gnt, m0_gnt, sbus.addr} !== {2'b00, 32'h10})
      $display("FAIL tie_req0: gnt=%b addr=%h want 00 10",
               {m1_gnt, m0_gnt}, sbus.addr);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({m0_done, m1_gnt, m0_gnt} !== 3'b110)
      $display("FAIL tie_second: done0=%b gnt=%b want 1 10", m0_done,
               {m1_gnt, m0_gnt});
    else n_pass++;
    @(negedge clk);
    m1_req = 0;
    #1;
    n_total++;
    if (sbus.addr !== 32'h20)
      $display("FAIL tie_addr1: got %h want 20", sbus.addr);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if (m1_done !== 1'b1)
      $display("FAIL tie_done1: got %b want 1", m1_done);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_alternate();
    int k;
    k = 0;
    do_reset();
    m0_req = 1; m1_req = 1; sbus.ack = 1; sbus.rvalid = 1;
    for (int c = 0; c < 40 && k < 8; c++) begin
      #1;
      if (m0_gnt || m1_gnt) begin
        n_total++;
        if ({m1_gnt, m0_gnt} !== (k[0] ? 2'b10 : 2'b01))
          $display("FAIL alt_grant%0d: got %b want %b", k,
                   {m1_gnt, m0_gnt}, k[0] ? 2'b10 : 2'b01);
        else n_pass++;
        k++;
      end
      @(negedge clk);
    end
    n_total++;
    if (k != 8) $display("FAIL alt_count: got %0d grants want 8", k);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_write_wait();
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 32'h200;
    m0_wdata = 32'h12345678; m0_wstrb = 4'h3;
    #1;
    n_total++;
    if (m0_gnt !== 1'b1) $display("FAIL wr_gnt: got %b want 1", m0_gnt);
    else n_pass++;
    @(negedge clk);
    m0_req = 0; sbus.ack = 1;
    #1;
    n_total++;
    if ({sbus.req, sbus.we, sbus.addr, sbus.wdata, sbus.wstrb} !==
        {2'b11, 32'h200, 32'h12345678, 4'h3})
      $display("FAIL wr_fields: req=%b we=%b a=%h d=%h s=%h", sbus.req,
               sbus.we, sbus.addr, sbus.wdata, sbus.wstrb);
    else n_pass++;
    @(negedge clk);
    sbus.ack = 0;
    #1;
    n_total++;
    if ({sbus.req, busy} !== 2'b01)
      $display("FAIL wr_wait: req=%b busy=%b want 0 1", sbus.req, busy);
    else n_pass++;
    @(negedge clk);
    #1;
    n_total++;
    if ({sbus.req, m0_done} !== 2'b00)
      $display("FAIL wr_wait2: req=%b done=%b want 0 0", sbus.req, m0_done);
    else n_pass++;
    @(negedge clk);
    sbus.rvalid = 1; sbus.rdata = 32'hCAFEF00D;
    #1;
    @(negedge clk);
    sbus.rvalid = 0;
    #1;
    n_total++;
    if ({m0_done, m0_err, m0_rdata} !== {2'b10, 32'h0})
      $display("FAIL wr_done: done=%b err=%b rdata=%h want 1 0 0",
               m0_done, m0_err, m0_rdata);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_timeout();
    int sreq_n;
    int dcyc;
    sreq_n = 0;
    dcyc = -1;
    do_reset();
    m1_req = 1; m1_addr = 32'h300;
    #1;
    n_total++;
    if (m1_gnt !== 1'b1) $display("FAIL to_gnt: got %b want 1", m1_gnt);
    else n_pass++;
    for (int c = 1; c <= 20 && dcyc < 0; c++) begin
      @(negedge clk);
      m1_req = 0; sbus.rvalid = 1; sbus.rdata = 32'h5555AAAA;
      #1;
      if (sbus.req) sreq_n++;
      if (m1_done) begin
        dcyc = c;
        n_total++;
        if ({m1_err, m1_rdata, busy} !== {1'b1, 32'h0, 1'b0})
          $display("FAIL to_abort: err=%b rdata=%h busy=%b want 1 0 0",
                   m1_err, m1_rdata, busy);
        else n_pass++;
      end
    end
    n_total++;
    if (sreq_n != TO)
      $display("FAIL to_sreq_len: got %0d want %0d", sreq_n, TO);
    else n_pass++;
    n_total++;
    if (dcyc != TO + 1)
      $display("FAIL to_done_cyc: got %0d want %0d", dcyc, TO + 1);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_rst_mid();
    do_reset();
    m0_req = 1; m0_addr = 32'h400;
    @(negedge clk);
    m0_req = 0; sbus.ack = 1;
    @(negedge clk);
    sbus.ack = 0;
    #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL rm_wait: busy=%b want 1", busy);
    else n_pass++;
    rst = 1;
    @(negedge clk);
    rst = 0; sbus.rvalid = 1; sbus.rdata = 32'h77;
    #1;
    n_total++;
    if ({busy, sbus.req, m0_done, m1_done} !== 4'b0)
      $display("FAIL rm_idle: busy=%b req=%b d0=%b d1=%b want 0",
               busy, sbus.req, m0_done, m1_done);
    else n_pass++;
    @(negedge clk);
    sbus.rvalid = 0;
    #1;
    n_total++;
    if ({m0_done, m1_done, m0_err, m0_rdata, sbus.addr} !== '0)
      $display("FAIL rm_nodone: d0=%b d1=%b e0=%b rd=%h addr=%h",
               m0_done, m1_done, m0_err, m0_rdata, sbus.addr);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    bit            pend[2];
    logic          q_we[2];
    logic [AW-1:0] q_addr[2];
    logic [DW-1:0] q_wd[2];
    logic [SW-1:0] q_ws[2];
    logic [DW-1:0] held_rd[2];
    logic          held_err[2];
    bit            open, last_win, exp_err, spur;
    int            own, s0, a, r, last, exp_done, o, w;
    logic [DW-1:0] exp_rd, rd_val;
    logic [1:0]    exp_v;
    open = 0; last_win = 1; own = 0; s0 = 0; a = 0; r = 0;
    last = 0; exp_done = 0; exp_err = 0; exp_rd = '0; rd_val = '0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; held_rd[i] = '0; held_err[i] = 0;
      q_we[i] = 0; q_addr[i] = '0; q_wd[i] = '0; q_ws[i] = '0;
    end
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 2; i++)
        if (!pend[i] && !(open && own == i && n < exp_done) &&
            n < 2900 && $urandom_range(3) == 0) begin
          pend[i] = 1;
          q_we[i] = 1'($urandom_range(1));
          q_addr[i] = $urandom; q_wd[i] = $urandom;
          q_ws[i] = SW'($urandom);
        end
      m0_req = pend[0]; m0_we = q_we[0]; m0_addr = q_addr[0];
      m0_wdata = q_wd[0]; m0_wstrb = q_ws[0];
      m1_req = pend[1]; m1_we = q_we[1]; m1_addr = q_addr[1];
      m1_wdata = q_wd[1]; m1_wstrb = q_ws[1];
      spur = ($urandom_range(3) == 0);
      sbus.ack = 0;
      sbus.rdata = $urandom;
      if (open && n >= s0) begin
        o = n - s0;
        sbus.ack = (o == a);
        sbus.rvalid = (o == r) || (spur && (a < 0 || o < a));
        if (o == r) sbus.rdata = rd_val;
      end else begin
        sbus.rvalid = spur;
      end
      #1;
      exp_v = (open && n == exp_done) ? (own ? 2'b10 : 2'b01) : 2'b00;
      n_total++;
      if ({m1_done, m0_done} !== exp_v)
        $display("FAIL rnd_done c%0d: got %b want %b", n,
                 {m1_done, m0_done}, exp_v);
      else n_pass++;
      if (open && n == exp_done) begin
        held_rd[own] = exp_rd;
        held_err[own] = exp_err;
        open = 0;
      end
      n_total++;
      if ({m1_rdata, m0_rdata, m1_err, m0_err} !==
          {held_rd[1], held_rd[0], held_err[1], held_err[0]})
        $display("FAIL rnd_resp c%0d: got %h %h %b%b want %h %h %b%b", n,
                 m1_rdata, m0_rdata, m1_err, m0_err, held_rd[1],
                 held_rd[0], held_err[1], held_err[0]);
      else n_pass++;
      n_total++;
      if ({sbus.req, busy} !==
          {open && n >= s0 && n <= s0 + last, open && n >= s0})
        $display("FAIL rnd_sreq_busy c%0d: got %b%b", n, sbus.req, busy);
      else n_pass++;
      if (open && n == s0) begin
        n_total++;
        if ({sbus.we, sbus.addr, sbus.wdata, sbus.wstrb} !==
            {q_we[own], q_addr[own], q_wd[own], q_ws[own]})
          $display("FAIL rnd_fields c%0d: got %b %h %h %h want %b %h %h %h",
                   n, sbus.we, sbus.addr, sbus.wdata, sbus.wstrb,
                   q_we[own], q_addr[own], q_wd[own], q_ws[own]);
        else n_pass++;
      end
      exp_v = 2'b00;
      w = 0;
      if (!open && (pend[0] || pend[1])) begin
        w = (pend[0] && pend[1]) ? int'(!last_win) : int'(pend[1]);
        exp_v = w[0] ? 2'b10 : 2'b01;
      end
      n_total++;
      if ({m1_gnt, m0_gnt} !== exp_v)
        $display("FAIL rnd_gnt c%0d: got %b want %b", n,
                 {m1_gnt, m0_gnt}, exp_v);
      else n_pass++;
      if (exp_v != 2'b00) begin
        open = 1; own = w; last_win = w[0]; pend[w] = 0; s0 = n + 1;
        a = ($urandom_range(7) == 0) ? -1 : int'($urandom_range(3));
        if (a < 0) r = -1;
        else r = ($urandom_range(7) == 0) ? -1 : a + int'($urandom_range(3));
        rd_val = $urandom;
        if (r >= 0) begin
          exp_done = s0 + r + 1; exp_err = 0; last = a;
          exp_rd = q_we[w] ? '0 : rd_val;
        end else begin
          exp_done = s0 + TO; exp_err = 1; exp_rd = '0;
          last = (a < 0) ? TO - 1 : a;
        end
      end
      @(negedge clk);
    end
    idle_inputs();
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1;
    idle_inputs();
    test_reset();
    test_read_min();
    test_tie();
    test_alternate();
    test_write_wait();
    test_timeout();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d",
             n_pass, n_total);
    $fatal(1);
  end
endmodule
